// File: rtl/reimu_shot_pkg.sv
// Shared game constants for the player-shot path and the enemy-collision stage.
package reimu_shot_pkg;

    // Screen coordinates are 10-bit unsigned throughout the game.
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Player playfield bounds (top-left corner of the player sprite).
    localparam int PLAYER_X_MIN = 0;
    localparam int PLAYER_X_MAX = 425;
    localparam int PLAYER_Y_MIN = 25;
    localparam int PLAYER_Y_MAX = 455;

    // Player spawn point after reset / gameover.
    localparam int PLAYER_X_SPAWN = 220;
    localparam int PLAYER_Y_SPAWN = 360;

    // Shot defaults, shared with the collision stage's hitbox math.
    localparam int DEF_NSHOT    = 4;
    localparam int DEF_SPEED    = 10;
    localparam int DEF_COOLDOWN = 4;
    localparam int DEF_XOFF     = 10;
    localparam int DEF_YOFF     = 16;

    // What a single shot slot does on the coming tick.
    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_LOAD,
        SLOT_MOVE,
        SLOT_KILL
    } slot_op_e;

    // Muzzle position relative to the player sprite. Player bounds keep
    // these inside 10 bits with no wrap-around.
    function automatic coord_t muzzle_x(input coord_t px, input int xoff);
        return px + coord_t'(xoff);
    endfunction

    function automatic coord_t muzzle_y(input coord_t py, input int yoff);
        return py - coord_t'(yoff);
    endfunction

endpackage

// File: rtl/reimu_shot_if.sv
// Bundle between the player/collision side and the shot manager.
// master: player movement + collision stage driving the inputs.
// slave : the shot manager itself.
interface reimu_shot_if
    import reimu_shot_pkg::*;
#(
    parameter int NSHOT = DEF_NSHOT
) ();

    logic                       gameover;
    logic                       fire;
    coord_t                     reimux;
    coord_t                     reimuy;
    logic [NSHOT-1:0]           hit_clr;
    logic [NSHOT-1:0]           shot_active;
    logic [COORD_W*NSHOT-1:0]   shotx;
    logic [COORD_W*NSHOT-1:0]   shoty;
    logic                       fire_pulse;

    modport master (
        output gameover, fire, reimux, reimuy, hit_clr,
        input  shot_active, shotx, shoty, fire_pulse
    );

    modport slave (
        input  gameover, fire, reimux, reimuy, hit_clr,
        output shot_active, shotx, shoty, fire_pulse
    );

endinterface

// File: rtl/reimu_shot_slot.sv
// One shot slot: holds active/x/y, loads at the muzzle, flies upward,
// and dies on a collision clear or when it would pass the top edge.
module reimu_shot_slot
    import reimu_shot_pkg::*;
#(
    parameter int SPEED = DEF_SPEED
) (
    input  logic   clk22,
    input  logic   i_clr,
    input  logic   i_load,
    input  coord_t i_load_x,
    input  coord_t i_load_y,
    input  logic   i_hit,
    output logic   o_active,
    output coord_t o_x,
    output coord_t o_y
);

    localparam coord_t SPEED_C = coord_t'(SPEED);

    logic     r_active;
    coord_t   r_x;
    coord_t   r_y;
    slot_op_e w_op;

    // Pick this tick's action; a fresh load wins over any motion.
    always_comb begin
        // NOTE: default assigned first so every path drives w_op and no latch is inferred.
        w_op = SLOT_HOLD;
        if (i_load) begin
            w_op = SLOT_LOAD;
        end else if (r_active) begin
            if (i_hit || (r_y < SPEED_C)) begin
                w_op = SLOT_KILL;
            end else begin
                w_op = SLOT_MOVE;
            end
        end
    end

    // Slot registers; a dead slot keeps its last coordinates.
    always_ff @(posedge clk22) begin
        // NOTE: coordinates are cleared along with active so the renderer never sees stale data after reset.
        if (i_clr) begin
            // NOTE: non-blocking assignments keep all slots updating from the same pre-edge state.
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            case (w_op)
                SLOT_LOAD: begin
                    r_active <= 1'b1;
                    r_x      <= i_load_x;
                    r_y      <= i_load_y;
                end
                SLOT_MOVE: r_y      <= r_y - SPEED_C;
                SLOT_KILL: r_active <= 1'b0;
                default:   ;
            endcase
        end
    end

    assign o_active = r_active;
    assign o_x      = r_x;
    assign o_y      = r_y;

endmodule

// File: rtl/reimu_shot.sv
// Player-shot manager: spawns shots from a fixed pool at the player's
// muzzle with auto-fire cooldown, and exposes every slot to the renderer.
module reimu_shot
    import reimu_shot_pkg::*;
#(
    parameter int NSHOT    = DEF_NSHOT,
    parameter int SPEED    = DEF_SPEED,
    parameter int COOLDOWN = DEF_COOLDOWN,
    parameter int XOFF     = DEF_XOFF,
    parameter int YOFF     = DEF_YOFF
) (
    input logic         clk22,
    input logic         rst,
    reimu_shot_if.slave bus
);

    localparam int              CD_W    = $clog2(COOLDOWN) + 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);

    logic                     w_clr;
    logic [NSHOT-1:0]         w_active;
    logic [NSHOT-1:0]         w_pick;
    logic [NSHOT-1:0]         w_load;
    logic                     w_any_free;
    logic                     w_spawn;
    coord_t                   w_spawn_x;
    coord_t                   w_spawn_y;
    coord_t                   w_x [NSHOT];
    coord_t                   w_y [NSHOT];
    logic [COORD_W*NSHOT-1:0] w_shotx;
    logic [COORD_W*NSHOT-1:0] w_shoty;
    logic [CD_W-1:0]          r_cd;
    logic                     r_fire_pulse;

    // gameover behaves exactly like reset and holds the block cleared.
    assign w_clr = rst | bus.gameover;

    // Lowest-index inactive slot as a one-hot vector. Slots dying this
    // tick are still active pre-edge, so they are not offered.
    always_comb begin
        w_pick     = '0;
        w_any_free = 1'b0;
        for (int i = 0; i < NSHOT; i++) begin
            if (!w_active[i] && !w_any_free) begin
                w_pick[i]  = 1'b1;
                w_any_free = 1'b1;
            end
        end
    end

    // With the pool full the cooldown sits at zero, so the spawn fires on
    // the first tick a slot frees up.
    assign w_spawn   = bus.fire && (r_cd == '0) && w_any_free;
    assign w_load    = w_spawn ? w_pick : '0;
    assign w_spawn_x = muzzle_x(bus.reimux, XOFF);
    assign w_spawn_y = muzzle_y(bus.reimuy, YOFF);

    for (genvar g = 0; g < NSHOT; g++) begin : g_slot
        reimu_shot_slot #(
            .SPEED    (SPEED)
        ) u_slot (
            .clk22    (clk22),
            .i_clr    (w_clr),
            .i_load   (w_load[g]),
            .i_load_x (w_spawn_x),
            .i_load_y (w_spawn_y),
            .i_hit    (bus.hit_clr[g]),
            .o_active (w_active[g]),
            .o_x      (w_x[g]),
            .o_y      (w_y[g])
        );
    end

    // Auto-fire cooldown and the one-tick sound trigger.
    always_ff @(posedge clk22) begin
        if (w_clr) begin
            r_cd         <= '0;
            r_fire_pulse <= 1'b0;
        end else begin
            r_fire_pulse <= w_spawn;
            if (w_spawn) begin
                r_cd <= CD_LOAD;
            end else if (r_cd != '0) begin
                r_cd <= r_cd - 1'b1;
            end
        end
    end

    // Pack slot coordinates into the flat renderer buses.
    always_comb begin
        w_shotx = '0;
        w_shoty = '0;
        for (int i = 0; i < NSHOT; i++) begin
            w_shotx[COORD_W*i +: COORD_W] = w_x[i];
            w_shoty[COORD_W*i +: COORD_W] = w_y[i];
        end
    end

    assign bus.shot_active = w_active;
    assign bus.shotx       = w_shotx;
    assign bus.shoty       = w_shoty;
    assign bus.fire_pulse  = r_fire_pulse;

endmodule

// File: tb/tb_reimu_shot.sv
// Bench for reimu_shot: a rule-level shot-pool model checked every tick,
// plus directed scenarios with hand-computed expectations.
module tb_reimu_shot;

    localparam int NS       = 4;
    localparam int SPEED    = 10;
    localparam int COOLDOWN = 4;
    localparam int XOFF     = 10;
    localparam int YOFF     = 16;

    logic clk22 = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    // Rule-level model state.
    int m_act [NS];
    int m_x   [NS];
    int m_y   [NS];
    int m_cd;
    int m_pulse;

    reimu_shot_if #(.NSHOT(NS)) bus ();

    reimu_shot #(
        .NSHOT    (NS),
        .SPEED    (SPEED),
        .COOLDOWN (COOLDOWN),
        .XOFF     (XOFF),
        .YOFF     (YOFF)
    ) u_dut (
        .clk22 (clk22),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk22 = ~clk22;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Advance one tick of the model from the inputs seen at the edge.
    task automatic model_step();
        int pick;
        bit spawn;
        if (rst || bus.gameover) begin
            for (int i = 0; i < NS; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_cd    = 0;
            m_pulse = 0;
        end else begin
            pick = -1;
            for (int i = 0; i < NS; i++)
                if (m_act[i] == 0 && pick < 0) pick = i;
            spawn = bus.fire && (m_cd == 0) && (pick >= 0);
            for (int i = 0; i < NS; i++) begin
                if (m_act[i] != 0) begin
                    if (bus.hit_clr[i])   m_act[i] = 0;
                    else if (m_y[i] < SPEED) m_act[i] = 0;
                    else                  m_y[i] = m_y[i] - SPEED;
                end
            end
            if (spawn) begin
                m_act[pick] = 1;
                m_x[pick]   = int'(bus.reimux) + XOFF;
                m_y[pick]   = int'(bus.reimuy) - YOFF;
                m_cd        = COOLDOWN - 1;
            end else if (m_cd > 0) begin
                m_cd = m_cd - 1;
            end
            m_pulse = spawn ? 1 : 0;
        end
    endtask

    // Compare process: step the model at each edge, check the DUT just after.
    initial begin
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cd = 0;
        m_pulse = 0;
        forever begin
            logic [NS-1:0] exp_act;
            @(posedge clk22);
            model_step();
            #1;
            exp_act = '0;
            for (int i = 0; i < NS; i++) exp_act[i] = (m_act[i] != 0);
            check("model_active", 64'(bus.shot_active), 64'(exp_act));
            check("model_pulse", 64'(bus.fire_pulse), 64'(m_pulse));
            for (int i = 0; i < NS; i++) begin
                if (m_act[i] != 0) begin
                    check($sformatf("model_x%0d", i), 64'(bus.shotx[10*i +: 10]), 64'(m_x[i]));
                    check($sformatf("model_y%0d", i), 64'(bus.shoty[10*i +: 10]), 64'(m_y[i]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk22);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.fire = 1'b0;
        bus.hit_clr = '0;
        bus.gameover = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic check_slot(input string name, input int i, input int x, input int y);
        check({name, "_act"}, 64'(bus.shot_active[i]), 64'd1);
        check({name, "_x"}, 64'(bus.shotx[10*i +: 10]), 64'(x));
        check({name, "_y"}, 64'(bus.shoty[10*i +: 10]), 64'(y));
    endtask

    // Directed scenarios; inputs change on the falling edge.
    initial begin
        rst = 1'b1;
        bus.gameover = 1'b0;
        bus.fire = 1'b0;
        bus.hit_clr = '0;
        bus.reimux = 10'd220;
        bus.reimuy = 10'd360;
        tick(2);
        rst = 1'b0;
        check("rst_active", 64'(bus.shot_active), 64'd0);
        check("rst_shotx", 64'(bus.shotx), 64'd0);
        check("rst_shoty", 64'(bus.shoty), 64'd0);
        check("rst_pulse", 64'(bus.fire_pulse), 64'd0);
        tick(1);

        // Single shot: spawn, first move, flight to the top, retire.
        bus.fire = 1'b1;
        tick(1);
        bus.fire = 1'b0;
        check_slot("s1_spawn", 0, 230, 344);
        check("s1_pulse_hi", 64'(bus.fire_pulse), 64'd1);
        check("s1_active", 64'(bus.shot_active), 64'b0001);
        tick(1);
        check("s1_move_y", 64'(bus.shoty[9:0]), 64'd334);
        check("s1_pulse_lo", 64'(bus.fire_pulse), 64'd0);
        bus.hit_clr = 4'b1110;   // clears aimed at empty slots do nothing
        tick(33);
        bus.hit_clr = '0;
        check_slot("s1_top", 0, 230, 4);
        tick(1);
        check("s1_retired", 64'(bus.shot_active), 64'd0);

        // Held fire: spawns every 4 ticks, pool fills, slot0 recycles.
        bus.fire = 1'b1;
        tick(1);
        check("s2_t0", 64'(bus.shot_active), 64'b0001);
        tick(3);
        check("s2_t3", 64'(bus.shot_active), 64'b0001);
        check("s2_t3_pulse", 64'(bus.fire_pulse), 64'd0);
        tick(1);
        check("s2_t4", 64'(bus.shot_active), 64'b0011);
        check("s2_t4_pulse", 64'(bus.fire_pulse), 64'd1);
        tick(4);
        check("s2_t8", 64'(bus.shot_active), 64'b0111);
        tick(4);
        check("s2_t12", 64'(bus.shot_active), 64'b1111);
        tick(23);
        check("s2_t35", 64'(bus.shot_active), 64'b1110);
        check("s2_t35_pulse", 64'(bus.fire_pulse), 64'd0);
        tick(1);
        check("s2_t36", 64'(bus.shot_active), 64'b1111);
        check("s2_t36_pulse", 64'(bus.fire_pulse), 64'd1);
        check("s2_t36_y0", 64'(bus.shoty[9:0]), 64'd344);
        bus.fire = 1'b0;

        // Collision clear on slot1 while a spawn is due: spawn goes to slot3.
        do_reset();
        bus.fire = 1'b1;
        tick(12);
        check("s3_t11", 64'(bus.shot_active), 64'b0111);
        bus.hit_clr = 4'b0010;
        tick(1);
        bus.hit_clr = '0;
        check("s3_t12", 64'(bus.shot_active), 64'b1101);
        check("s3_t12_pulse", 64'(bus.fire_pulse), 64'd1);
        check_slot("s3_slot3", 3, 230, 344);
        check("s3_y0", 64'(bus.shoty[9:0]), 64'd224);
        tick(4);
        check("s3_t16", 64'(bus.shot_active), 64'b1111);
        check_slot("s3_slot1", 1, 230, 344);
        bus.fire = 1'b0;

        // gameover mid-flight with 3 live shots and cooldown at 2.
        do_reset();
        bus.fire = 1'b1;
        tick(10);
        check("s5_pre", 64'(bus.shot_active), 64'b0111);
        bus.gameover = 1'b1;
        tick(1);
        check("s5_active", 64'(bus.shot_active), 64'd0);
        check("s5_shotx", 64'(bus.shotx), 64'd0);
        check("s5_shoty", 64'(bus.shoty), 64'd0);
        tick(4);
        check("s5_held", 64'(bus.shot_active), 64'd0);
        check("s5_held_pulse", 64'(bus.fire_pulse), 64'd0);
        bus.gameover = 1'b0;
        tick(1);
        check("s5_release", 64'(bus.shot_active), 64'b0001);
        check("s5_release_pulse", 64'(bus.fire_pulse), 64'd1);
        bus.fire = 1'b0;

        // Corner spawn: top-left player position, shot retires next tick.
        do_reset();
        bus.reimux = 10'd0;
        bus.reimuy = 10'd25;
        bus.fire = 1'b1;
        tick(1);
        bus.fire = 1'b0;
        check_slot("s6_spawn", 0, 10, 9);
        tick(1);
        check("s6_retired", 64'(bus.shot_active), 64'd0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reimu_shot.md
# reimu_shot

Player-shot manager sitting directly downstream of the player-movement block. It consumes the player position `reimux`/`reimuy` and a fire button, spawns shots from a fixed pool at the player's muzzle, and moves every live shot upward once per `clk22` tick. Shots retire at the top of the playfield or when the collision stage clears them. Outputs feed the VGA renderer and the enemy-collision stage.

## Interface
Parameters:
- `NSHOT`, 4: shot pool size (slots 0..NSHOT-1).
- `SPEED`, 10: pixels moved up per tick.
- `COOLDOWN`, 4: minimum ticks between spawns while fire is held.
- `XOFF`, 10: spawn x offset added to `reimux`.
- `YOFF`, 16: spawn y offset subtracted from `reimuy`.

Ports:
- `clk22`  in  1: game tick clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `gameover`  in  1: synchronous clear, same effect as `rst`.
- `fire`  in  1: fire button level (held = auto-fire).
- `reimux`  in  10: player x, 0..425.
- `reimuy`  in  10: player y, 25..455.
- `hit_clr`  in  NSHOT: per-slot clear request from the collision stage.
- `shot_active`  out  NSHOT: slot i holds a live shot.
- `shotx`  out  10*NSHOT: slot i x at bits [10i+9:10i].
- `shoty`  out  10*NSHOT: slot i y at bits [10i+9:10i].
- `fire_pulse`  out  1: high for exactly the tick in which a spawn occurred (sound trigger).

## Operation
- State: per-slot `active`, x, y; cooldown counter `cd` (width ≥ clog2(COOLDOWN)+1); `fire_pulse` register.
- Reset / gameover: all `active`=0, all x/y=0, `cd`=0, `fire_pulse`=0. `gameover` held keeps the block in this state.
- Free-slot search: lowest index i with `active[i]`=0, evaluated on the pre-edge state. A slot being cleared or retired this tick is not free this tick.
- Spawn condition: `fire`=1 AND `cd`=0 AND a free slot exists. On spawn: slot ← active, x=`reimux`+XOFF, y=`reimuy`-YOFF; `cd`←COOLDOWN-1; `fire_pulse`←1.
- No spawn: `fire_pulse`←0; `cd` decrements if nonzero, else stays 0. If the pool is full with `fire`=1 and `cd`=0, `cd` stays 0 and the spawn occurs on the first tick a slot is free.
- Per-slot update for each active slot not spawned this tick, in priority order:
  1. `hit_clr[i]`=1 → `active`←0.
  2. Else if y < SPEED → `active`←0 (retire at top).
  3. Else y ← y − SPEED.
- `hit_clr` on an inactive slot is ignored.
- Deactivated slots keep their last x/y. Verification checks coordinates only where `active`=1.
- Arithmetic: all 10-bit unsigned. Player ranges guarantee x ≤ 435 and y ≥ 9, so no wrap-around can occur. x never changes after spawn.

## Timing
- Every register updates on posedge `clk22`; no combinational path from inputs to outputs.
- Spawn is visible on outputs the tick after `fire` is sampled. A newly spawned shot first moves on the following tick.
- With `fire` held and free slots available, spawns occur every COOLDOWN ticks.
- Shot lifetime from spawn y0 is floor(y0/SPEED)+1 ticks, assuming no clear.

## Structure
- Shared game package: playfield bounds, player spawn constants, and the XOFF/YOFF/SPEED defaults. The enemy-collision stage uses the same values.
- Sub-module `reimu_shot_slot`: one slot's active/x/y registers with load, move, and clear inputs, generated NSHOT times.
- Top level holds the free-slot priority encoder, cooldown counter, and `fire_pulse`.

## Test plan
- Reset, then hold `fire` one tick with (`reimux`, `reimuy`)=(220, 360) → slot0 active at (230, 344), `fire_pulse`=1 for one tick; next tick y=334.
- Single shot at y0=344 → after 34 move ticks y=4; on the next tick slot0 goes inactive.
- Hold `fire` continuously → spawns at ticks 0, 4, 8, 12 into slots 0–3; then no spawn and `cd`=0 while full; slot0 retires at tick 35 and is respawned at tick 36.
- Assert `hit_clr`=4'b0010 while slots 0–2 are active and `fire` is held with `cd`=0 → slot1 is cleared, slot3 receives the spawn, and slot1 is refilled on the next eligible spawn.
- Assert `gameover` mid-flight with 3 live shots and `cd`=2 → next tick all inactive, x/y=0, `cd`=0; `fire` is ignored while `gameover` is held.
- Set `reimux`=0, `reimuy`=25, `fire` → spawn at (10, 9); on the next tick the shot retires (9 < 10) with no underflow.
